// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS-subset core: stalls, bubbles, IF/ID flush, branch PC select
// and EX operand forwarding. Define HAZARD_FWD_EN for forwarding; otherwise hazards are fully interlocked.
module hazard_ctrl #(
    parameter int unsigned BR_PENALTY = 2,
    parameter logic [31:0] BUBBLE     = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_ir,
    input  logic [31:0] ex_ir,
    input  logic [31:0] mem_ir,
    input  logic [31:0] wb_ir,
    input  logic        ex_cond,
    output logic        stall_if,
    output logic        bubble_ex,
    output logic        flush_id,
    output logic        pc_sel,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    // Destination register written by an instruction; 0 means it writes nothing we care about.
    function automatic logic [4:0] dest_of(input logic [31:0] ir);
        logic [5:0] op;
        op      = ir[31:26];
        dest_of = 5'd0;
        if (ir != BUBBLE) begin
            if (op == OP_RTYPE)
                dest_of = ir[15:11];
            else if (op[5:3] == 3'b001 || op == OP_LW)
                dest_of = ir[20:16];
        end
    endfunction

    function automatic logic src_match(
        input logic [4:0] dest,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       rs_used,
        input logic       rt_used
    );
        src_match = (dest != 5'd0) &&
                    ((rs_used && rs == dest) || (rt_used && rt == dest));
    endfunction

    logic [5:0] id_op;
    logic [4:0] id_rs, id_rt;
    logic       id_is_bubble;
    logic       rs_used, rt_used;
    logic [4:0] ex_dest, mem_dest, wb_dest;
    logic       hit_ex, hit_mem, hit_wb;
    logic       load_use;
    logic       branch_taken;
    logic       stall_req;

    assign id_op        = id_ir[31:26];
    assign id_rs        = id_ir[25:21];
    assign id_rt        = id_ir[20:16];
    assign id_is_bubble = (id_ir == BUBBLE);
    assign rs_used      = !id_is_bubble && (id_op != OP_J);
    assign rt_used      = !id_is_bubble &&
                          (id_op == OP_RTYPE || id_op == OP_BEQ || id_op == OP_SW);

    assign ex_dest  = dest_of(ex_ir);
    assign mem_dest = dest_of(mem_ir);
    assign wb_dest  = dest_of(wb_ir);

    assign hit_ex  = src_match(ex_dest,  id_rs, id_rt, rs_used, rt_used);
    assign hit_mem = src_match(mem_dest, id_rs, id_rt, rs_used, rt_used);
    assign hit_wb  = src_match(wb_dest,  id_rs, id_rt, rs_used, rt_used);

    assign load_use     = (ex_ir[31:26] == OP_LW) && hit_ex;
    assign branch_taken = (ex_ir[31:26] == OP_BEQ) && ex_cond;

    logic [1:0] fwd_a_c, fwd_b_c;

`ifdef HAZARD_FWD_EN
    // A load in MEM has no data yet, so only WB can supply its result.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] mdest,
        input logic       m_ok,
        input logic [4:0] wdest
    );
        fwd_sel = 2'd0;
        if (src != 5'd0) begin
            if (m_ok && mdest == src)
                fwd_sel = 2'd1;
            else if (wdest == src)
                fwd_sel = 2'd2;
        end
    endfunction

    logic mem_fwd_ok;

    assign mem_fwd_ok = (mem_ir[31:26] != OP_LW);
    assign fwd_a_c    = fwd_sel(ex_ir[25:21], mem_dest, mem_fwd_ok, wb_dest);
    assign fwd_b_c    = fwd_sel(ex_ir[20:16], mem_dest, mem_fwd_ok, wb_dest);
    assign stall_req  = load_use;
`else
    assign fwd_a_c   = 2'd0;
    assign fwd_b_c   = 2'd0;
    assign stall_req = load_use | hit_ex | hit_mem | hit_wb;
`endif

    // Stage latches capture on the falling edge, so the sequencer does too.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic stall_c, bubble_c, flush_c, pc_c;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        pc_c     = 1'b0;
        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    pc_c     = 1'b1;
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (BR_PENALTY > 1) begin
                        state_d = FLUSH;
                        cnt_d   = 3'(BR_PENALTY - 1);
                    end
                end else if (stall_req) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                end
            end
            FLUSH: begin
                flush_c  = 1'b1;
                bubble_c = 1'b1;
                if (cnt_q <= 3'd1) begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Outputs are combinational from the IRs, so they must be masked while reset is held.
    assign stall_if  = rst & stall_c;
    assign bubble_ex = rst & bubble_c;
    assign flush_id  = rst & flush_c;
    assign pc_sel    = rst & pc_c;
    assign fwd_a     = rst ? fwd_a_c : 2'd0;
    assign fwd_b     = rst ? fwd_b_c : 2'd0;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed IR vectors, expected outputs queued per cycle
// and compared by an independent monitor on the rising edge.
module tb_hazard_ctrl;

    localparam logic [31:0] B        = 32'hFFFF_FFFF;
    localparam logic [31:0] LW       = 32'h8C22_0000;  // lw  $2,0($1)
    localparam logic [31:0] LW_R0    = 32'h8C20_0000;  // lw  $0,0($1)
    localparam logic [31:0] LW_R5    = 32'h8C25_0000;  // lw  $5,0($1)
    localparam logic [31:0] ADD_U    = 32'h0044_1820;  // add $3,$2,$4
    localparam logic [31:0] ADD_R0   = 32'h0004_1820;  // add $3,$0,$4
    localparam logic [31:0] ADD2     = 32'h0021_1020;  // add $2,$1,$1
    localparam logic [31:0] SW2      = 32'hACA2_0000;  // sw  $2,0($5)
    localparam logic [31:0] JMP      = 32'h0840_0000;  // j with rs field = 2
    localparam logic [31:0] BEQ      = 32'h1020_0003;  // beq $1,$0,3
    localparam logic [31:0] ADDI4    = 32'h2004_0001;  // addi $4,$0,1
    localparam logic [31:0] MEM_ADD5 = 32'h00C7_2820;  // add $5,$6,$7
    localparam logic [31:0] WB_ADDI5 = 32'h2005_0001;  // addi $5,$0,1
    localparam logic [31:0] EX_RS5   = 32'h00A9_4020;  // add $8,$5,$9
    localparam logic [31:0] EX_RS0   = 32'h0009_4020;  // add $8,$0,$9
    localparam logic [31:0] EX_RT5   = 32'h0125_4020;  // add $8,$9,$5

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic       stall;
        logic       bubble;
        logic       flush;
        logic       pcsel;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_ir, ex_ir, mem_ir, wb_ir;
    logic        ex_cond;
    logic        stall_if, bubble_ex, flush_id, pc_sel;
    logic [1:0]  fwd_a, fwd_b;

    exp_t  exp_q[$];
    string name_q[$];
    int    compared   = 0;
    int    mismatched = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.BR_PENALTY(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .id_ir    (id_ir),
        .ex_ir    (ex_ir),
        .mem_ir   (mem_ir),
        .wb_ir    (wb_ir),
        .ex_cond  (ex_cond),
        .stall_if (stall_if),
        .bubble_ex(bubble_ex),
        .flush_id (flush_id),
        .pc_sel   (pc_sel),
        .fwd_a    (fwd_a),
        .fwd_b    (fwd_b)
    );

    function automatic exp_t mk(input logic s, input logic b, input logic f, input logic p,
                                input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e.stall  = s;
        e.bubble = b;
        e.flush  = f;
        e.pcsel  = p;
        e.fa     = fa;
        e.fb     = fb;
        return e;
    endfunction

    // Inputs change just after the falling (active) edge; the expected response is queued with them.
    task automatic applyStimulus(input logic r, input logic [31:0] id, input logic [31:0] ex,
                                 input logic [31:0] mem, input logic [31:0] wb, input logic cond,
                                 input exp_t e, input string nm);
        @(negedge clk);
        #1;
        rst     = r;
        id_ir   = id;
        ex_ir   = ex;
        mem_ir  = mem;
        wb_ir   = wb;
        ex_cond = cond;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic checkOutput(input exp_t e, input string nm);
        exp_t got;
        got = {stall_if, bubble_ex, flush_id, pc_sel, fwd_a, fwd_b};
        compared++;
        if (got !== e) begin
            mismatched++;
            $display("[TB] FAIL %s: got stall=%b bub=%b flush=%b pc=%b fa=%0d fb=%0d, want stall=%b bub=%b flush=%b pc=%b fa=%0d fb=%0d",
                     nm, got.stall, got.bubble, got.flush, got.pcsel, got.fa, got.fb,
                     e.stall, e.bubble, e.flush, e.pcsel, e.fa, e.fb);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0)
                checkOutput(exp_q.pop_front(), name_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t z, stl, br, fl, dep;
        z   = mk(0, 0, 0, 0, 2'd0, 2'd0);
        stl = mk(1, 1, 0, 0, 2'd0, 2'd0);
        br  = mk(0, 1, 1, 1, 2'd0, 2'd0);
        fl  = mk(0, 1, 1, 0, 2'd0, 2'd0);
        dep = FWD ? z : stl;

        rst     = 1'b0;
        id_ir   = B;
        ex_ir   = B;
        mem_ir  = B;
        wb_ir   = B;
        ex_cond = 1'b0;

        applyStimulus(0, $urandom(), $urandom(), $urandom(), $urandom(), 1, z, "rst_rand");
        applyStimulus(0, ADD_U, LW, ADD2, ADD2, 1, z, "rst_lw");
        applyStimulus(0, ADD_U, BEQ, LW, B, 1, z, "rst_beq");
        applyStimulus(1, B, B, B, B, 0, z, "idle_a");
        applyStimulus(1, B, B, B, B, 1, z, "idle_b");

        applyStimulus(1, ADD_U, LW, B, B, 0, stl, "lu_ex");
        applyStimulus(1, ADD_U, B, LW, B, 0, dep, "lu_mem");
        applyStimulus(1, ADD_U, B, B, LW, 0, dep, "lu_wb");
        applyStimulus(1, ADD_U, B, B, B, 0, z, "lu_clear");
        applyStimulus(1, SW2, LW, B, B, 0, stl, "lu_sw_rt");
        applyStimulus(1, JMP, LW, B, B, 0, z, "lu_jump");
        applyStimulus(1, ADD_R0, LW_R0, B, B, 0, z, "lu_reg0");

        applyStimulus(1, B, EX_RS5, MEM_ADD5, WB_ADDI5, 0,
                      FWD ? mk(0, 0, 0, 0, 2'd1, 2'd0) : z, "fwd_mem");
        applyStimulus(1, B, EX_RS5, B, WB_ADDI5, 0,
                      FWD ? mk(0, 0, 0, 0, 2'd2, 2'd0) : z, "fwd_wb");
        applyStimulus(1, B, EX_RS0, MEM_ADD5, WB_ADDI5, 0, z, "fwd_rs0");
        applyStimulus(1, B, EX_RT5, B, WB_ADDI5, 0,
                      FWD ? mk(0, 0, 0, 0, 2'd0, 2'd2) : z, "fwd_b_wb");
        applyStimulus(1, B, EX_RS5, LW_R5, WB_ADDI5, 0,
                      FWD ? mk(0, 0, 0, 0, 2'd2, 2'd0) : z, "fwd_mem_lw");

        applyStimulus(1, B, BEQ, B, B, 0, z, "beq_not_taken");
        applyStimulus(1, B, BEQ, B, B, 1, br, "beq_taken");
        applyStimulus(1, B, B, B, B, 0, fl, "flush_1");
        applyStimulus(1, B, B, B, B, 0, z, "after_branch");

        applyStimulus(1, ADD_U, BEQ, LW, ADD2, 1, br, "branch_vs_stall");
        applyStimulus(1, ADD_U, B, LW, B, 0, fl, "flush_no_stall");
        applyStimulus(1, B, B, B, B, 0, z, "after_branch2");

        applyStimulus(1, B, BEQ, B, B, 1, br, "beq_taken2");
        applyStimulus(0, B, B, B, B, 0, z, "flush_reset");
        #2 rst = 1'b1;
        applyStimulus(1, B, B, B, B, 0, z, "post_reset");

        applyStimulus(1, ADD_U, ADD2, B, B, 0, dep, "raw_ex");
        applyStimulus(1, ADD_U, B, ADD2, B, 0, dep, "raw_mem");
        applyStimulus(1, ADD_U, B, B, ADD2, 0, dep, "raw_wb");
        applyStimulus(1, ADD_U, B, B, B, 0, z, "raw_clear");
        applyStimulus(1, ADD_U, ADDI4, B, B, 0, dep, "raw_addi_rt");

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
